// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcode encodings,
// FSM state encoding and the opcode legality helper.
package alu_pkg;

   localparam logic [2:0] OP_OR  = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Opcodes 110/111 have no gate unit behind the ALU mux.
   function automatic logic op_is_legal(input logic [2:0] op);
      case (op)
         OP_OR, OP_AND, OP_XOR, OP_NOT, OP_ADD, OP_SUB: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Purely combinational; the caller owns
// the last_grant register (0 = requester 0 was granted last).
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot grant; on contention the requester not served last wins.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU between two requesters. Commands are
// arbitrated round-robin, operands are driven and held for ALU_LAT cycles,
// the result is captured and returned tagged with the requester id.
// Optional build macro: ALU_SCHED_STATS_EN adds per-requester completion
// counters done_cnt0/done_cnt1.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | accepting one command; ready offered to the granted side
//   ST_EXEC | alu_* held, latency down-counter running, capture at 0
//   ST_RESP | rsp_valid high, waiting for rsp_ready
module alu_req_scheduler
   import alu_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_r,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err
`ifdef ALU_SCHED_STATS_EN
   ,
   output logic [15:0]      done_cnt0,
   output logic [15:0]      done_cnt1
`endif
);

   localparam int              CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

   state_t             r_state;
   logic               r_last_grant;
   logic [CNT_W-1:0]   r_cnt;

   logic [1:0]         w_grant;
   logic               w_idle;
   logic               w_sel;
   logic               w_hs;
   logic [2:0]         w_op;
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;

   rr_arbiter2 u_arb (
      .req        ({req1_valid, req0_valid}),
      .last_grant (r_last_grant),
      .grant      (w_grant)
   );

   // Readies are held low while reset is asserted so no handshake is seen.
   assign w_idle     = (r_state == ST_IDLE) && !rst;
   assign req0_ready = w_idle && w_grant[0];
   assign req1_ready = w_idle && w_grant[1];

   assign w_sel = w_grant[1];
   assign w_hs  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign w_op  = w_sel ? req1_op : req0_op;
   assign w_a   = w_sel ? req1_a  : req0_a;
   assign w_b   = w_sel ? req1_b  : req0_b;

   // Sequencing FSM with registered ALU operands and response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         alu_op       <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_last_grant <= w_sel;
                  rsp_id       <= w_sel;
                  if (op_is_legal(w_op)) begin
                     alu_op  <= w_op;
                     alu_a   <= w_a;
                     alu_b   <= w_b;
                     r_cnt   <= CNT_LOAD;
                     r_state <= ST_EXEC;
                  end else begin
                     // ALU is left untouched so it does not toggle for a reject.
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     r_state   <= ST_RESP;
                  end
               end
            end
            ST_EXEC: begin
               if (r_cnt == '0) begin
                  rsp_data  <= alu_r;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  r_state   <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_SCHED_STATS_EN
   // Completed response handshakes per requester, errors included; wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_cnt0 <= 16'd0;
         done_cnt1 <= 16'd0;
      end else if (r_state == ST_RESP && rsp_valid && rsp_ready) begin
         if (rsp_id) done_cnt1 <= done_cnt1 + 16'd1;
         else        done_cnt0 <= done_cnt0 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: one instance with ALU_LAT=1 checked through a
// response scoreboard, and a second instance with ALU_LAT=3 for the held
// operand window. Stats counters are checked when ALU_SCHED_STATS_EN is set.
module tb_alu_req_scheduler;

   typedef struct {
      logic        id;
      logic [15:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   exp_t        sb[$];

   // instance 1 (ALU_LAT = 1)
   logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [2:0]  req0_op = 0, req1_op = 0, alu_op;
   logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [15:0] alu_a, alu_b, alu_r, rsp_data;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
   logic [15:0] done_cnt0, done_cnt1;

   // instance 2 (ALU_LAT = 3)
   logic        s0_valid = 0, s0_ready, s1_ready;
   logic [2:0]  s0_op = 0, s_alu_op;
   logic [15:0] s0_a = 0, s0_b = 0, s_alu_a, s_alu_b, s_alu_r, s_rsp_data;
   logic        s_rsp_valid, s_rsp_ready = 1'b1, s_rsp_id, s_rsp_err;
   logic [15:0] s_done_cnt0, s_done_cnt1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0:    return a | b;
         3'd1:    return a & b;
         3'd2:    return a ^ b;
         3'd3:    return ~a;
         3'd4:    return a + b;
         3'd5:    return a - b;
         default: return 16'hDEAD;
      endcase
   endfunction

   assign alu_r   = alu_f(alu_op, alu_a, alu_b);
   assign s_alu_r = alu_f(s_alu_op, s_alu_a, s_alu_b);

   alu_req_scheduler #(.WIDTH(16), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst(rst),
`ifdef ALU_SCHED_STATS_EN
      .done_cnt0(done_cnt0), .done_cnt1(done_cnt1),
`endif
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   alu_req_scheduler #(.WIDTH(16), .ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
`ifdef ALU_SCHED_STATS_EN
      .done_cnt0(s_done_cnt0), .done_cnt1(s_done_cnt1),
`endif
      .req0_valid(s0_valid), .req0_ready(s0_ready), .req0_op(s0_op),
      .req0_a(s0_a), .req0_b(s0_b),
      .req1_valid(1'b0), .req1_ready(s1_ready), .req1_op(3'd0),
      .req1_a(16'd0), .req1_b(16'd0),
      .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_r(s_alu_r),
      .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
      .rsp_data(s_rsp_data), .rsp_err(s_rsp_err)
   );

`ifndef ALU_SCHED_STATS_EN
   assign done_cnt0   = 16'd0;
   assign done_cnt1   = 16'd0;
   assign s_done_cnt0 = 16'd0;
   assign s_done_cnt1 = 16'd0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every response handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_rsp", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_id",   rsp_id,   e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_err",  rsp_err,  e.err);
         end
      end
   end

   // Drives one or both requesters (called at posedge+1); each drops valid
   // right after its handshake. h0/h1 are the handshake cycles (-1 if none).
   task automatic issue2(input bit e0, input bit e1,
                         input logic [2:0] o0, input logic [15:0] x0, input logic [15:0] y0,
                         input logic [2:0] o1, input logic [15:0] x1, input logic [15:0] y1,
                         output int h0, output int h1);
      bit p0, p1, s0, s1;
      p0 = e0; p1 = e1; h0 = -1; h1 = -1;
      req0_op = o0; req0_a = x0; req0_b = y0; req0_valid = e0;
      req1_op = o1; req1_a = x1; req1_b = y1; req1_valid = e1;
      for (int i = 0; i < 40 && (p0 || p1); i++) begin
         @(negedge clk);
         check("one_ready", req0_ready & req1_ready, 0);
         s0 = req0_valid && req0_ready;
         s1 = req1_valid && req1_ready;
         if (s0) h0 = cyc;
         if (s1) h1 = cyc;
         step();
         if (s0) begin req0_valid = 0; p0 = 0; end
         if (s1) begin req1_valid = 0; p1 = 0; end
      end
      if (p0) check("hs0_timeout", 0, 1);
      if (p1) check("hs1_timeout", 0, 1);
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic wait_rsp(input int hs, output int lat);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = cyc - hs;
            break;
         end
      end
      if (lat < 0) check("rsp_timeout", 0, 1);
   endtask

   initial begin
      int h0, h1, lat, hs;
      exp_t e;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id",    rsp_id,    0);
      check("rst_rsp_data",  rsp_data,  0);
      check("rst_rsp_err",   rsp_err,   0);
      check("rst_alu_op",    alu_op,    0);
      check("rst_alu_a",     alu_a,     0);
      check("rst_alu_b",     alu_b,     0);
      check("rst_ready0",    req0_ready, 0);
      check("rst_ready1",    req1_ready, 0);
      step();
      rst = 0;

      // 1: req0 OR 248|327
      step();
      e = '{1'b0, 16'h01FF, 1'b0}; sb.push_back(e);
      issue2(1, 0, 3'd0, 16'd248, 16'd327, 3'd0, 16'd0, 16'd0, h0, h1);
      check("t1_alu_op", alu_op, 3'd0);
      check("t1_alu_a",  alu_a,  16'd248);
      check("t1_alu_b",  alu_b,  16'd327);
      wait_rsp(h0, lat);
      check("t1_latency", lat, 2);

      // 2: fresh reset, both ADD 0xFFFF+1 together
      step();
      rst = 1;
      step();
      rst = 0;
      e = '{1'b0, 16'h0000, 1'b0}; sb.push_back(e);
      e = '{1'b1, 16'h0000, 1'b0}; sb.push_back(e);
      issue2(1, 1, 3'd4, 16'hFFFF, 16'h0001, 3'd4, 16'hFFFF, 16'h0001, h0, h1);
      check("t2_req0_first", (h0 >= 0 && h0 < h1), 1);
      check("t2_no_gap", h1 - h0, 3);
      wait_rsp(h1, lat);
      check("t2_latency", lat, 2);

      // 3: req1 illegal opcode
      step();
      e = '{1'b1, 16'h0000, 1'b1}; sb.push_back(e);
      issue2(0, 1, 3'd0, 16'd0, 16'd0, 3'b110, 16'h1234, 16'h5678, h0, h1);
      wait_rsp(h1, lat);
      check("t3_latency", lat, 1);
      check("t3_alu_op_kept", alu_op, 3'd4);
      check("t3_alu_a_kept",  alu_a,  16'hFFFF);
      check("t3_alu_b_kept",  alu_b,  16'h0001);

      // 4: SUB 5-7 with the consumer stalled
      step();
      rsp_ready = 0;
      e = '{1'b0, 16'hFFFE, 1'b0}; sb.push_back(e);
      issue2(1, 0, 3'd5, 16'd5, 16'd7, 3'd0, 16'd0, 16'd0, h0, h1);
      wait_rsp(h0, lat);
      check("t4_latency", lat, 2);
      step();
      req1_op = 3'd0; req1_a = 16'h00F0; req1_b = 16'h000F; req1_valid = 1;
      req0_op = 3'd1; req0_a = 16'h00F0; req0_b = 16'h000F; req0_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_valid", rsp_valid, 1);
         check("t4_hold_data",  rsp_data,  16'hFFFE);
         check("t4_hold_id",    rsp_id,    0);
         check("t4_ready0",     req0_ready, 0);
         check("t4_ready1",     req1_ready, 0);
      end
      step();
      req0_valid = 0; req1_valid = 0;
      rsp_ready = 1;
      @(negedge clk);
      check("t4_rsp_hs", rsp_valid, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_single_rsp", rsp_valid, 0);
      end

      // 5: reset during EXEC, then contention must start from req0
      step();
      issue2(1, 0, 3'd4, 16'h1111, 16'h2222, 3'd0, 16'd0, 16'd0, h0, h1);
      check("t5_exec_alu_a", alu_a, 16'h1111);
      rst = 1;
      #1;
      check("t5_rst_alu_a", alu_a, 0);
      @(negedge clk);
      check("t5_rst_alu_op",    alu_op,    0);
      check("t5_rst_alu_b",     alu_b,     0);
      check("t5_rst_rsp_valid", rsp_valid, 0);
      step();
      step();
      rst = 0;
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 0);
      step();
      e = '{1'b0, 16'h3030, 1'b0}; sb.push_back(e);
      e = '{1'b1, 16'hFF00, 1'b0}; sb.push_back(e);
      issue2(1, 1, 3'd1, 16'hF0F0, 16'h3C3C, 3'd3, 16'h00FF, 16'h1234, h0, h1);
      check("t5_req0_first", (h0 >= 0 && h0 < h1), 1);
      check("t5_no_gap", h1 - h0, 3);
      wait_rsp(h1, lat);
      check("t5_latency", lat, 2);
      @(negedge clk);
      check("sb_drained", sb.size(), 0);
`ifdef ALU_SCHED_STATS_EN
      check("stats_cnt0", done_cnt0, 1);
      check("stats_cnt1", done_cnt1, 1);
`endif

      // 6: ALU_LAT=3 instance, XOR 0xAAAA^0x5555
      step();
`ifdef ALU_SCHED_STATS_EN
      check("t6_cnt0_before", s_done_cnt0, 0);
`endif
      s0_op = 3'd2; s0_a = 16'hAAAA; s0_b = 16'h5555; s0_valid = 1;
      hs = -1;
      for (int i = 0; i < 10 && hs < 0; i++) begin
         @(negedge clk);
         if (s0_ready) hs = cyc;
         step();
      end
      s0_valid = 0;
      if (hs < 0) check("t6_hs_timeout", 0, 1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("t6_hold_op",    s_alu_op,    3'd2);
         check("t6_hold_a",     s_alu_a,     16'hAAAA);
         check("t6_hold_b",     s_alu_b,     16'h5555);
         check("t6_hold_novld", s_rsp_valid, 0);
      end
      @(negedge clk);
      check("t6_rsp_valid", s_rsp_valid, 1);
      check("t6_latency",   cyc - hs,    4);
      check("t6_rsp_data",  s_rsp_data,  16'hFFFF);
      check("t6_rsp_id",    s_rsp_id,    0);
      check("t6_rsp_err",   s_rsp_err,   0);
      step();
      @(negedge clk);
      check("t6_rsp_done", s_rsp_valid, 0);
`ifdef ALU_SCHED_STATS_EN
      check("t6_cnt0_after", s_done_cnt0, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=done", cyc);
      $fatal(1, "timeout");
   end

endmodule
